// File: rtl/nes_controller_reader.sv
// NES gamepad poller: periodically latches the pad, shifts out its 8 button bits and
// publishes the pressed flags plus a priority-encoded 4-bit code for Grid_Controller.
module nes_controller_reader #(
    parameter int HALF_BIT_CYCLES = 300,
    parameter int POLL_CYCLES     = 833333
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_pulse,
    output logic [7:0] buttons,
    output logic [3:0] controller_out,
    output logic       frame_valid,
    output logic [2:0] fsm_state
);

    localparam int POLL_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int PH_W   = $clog2(2 * HALF_BIT_CYCLES);

    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
    localparam logic [PH_W-1:0]   LATCH_LAST = PH_W'(2 * HALF_BIT_CYCLES - 1);
    localparam logic [PH_W-1:0]   HALF_LAST  = PH_W'(HALF_BIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_GAP    = 3'd2,
        S_P_HIGH = 3'd3,
        S_P_LOW  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            state;
    logic [POLL_W-1:0] poll_count;
    logic              poll_tick;
    logic [PH_W-1:0]   phase;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_reg;
    logic [7:0]        frame_bits;

    assign fsm_state = state;
    assign poll_tick = (poll_count == POLL_LAST);

    // Lowest set index wins; the loop runs high-to-low so the last hit is the lowest.
    function automatic logic [3:0] encode(input logic [7:0] b);
        logic [3:0] code;
        code = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (b[i]) begin
                code = 4'(i + 1);
            end
        end
        return code;
    endfunction

    // Shift register with the bit currently on the wire merged in (data is active-low).
    always_comb begin
        frame_bits          = shift_reg;
        frame_bits[bit_idx] = ~nes_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            poll_count <= '0;
        end else if (poll_tick) begin
            poll_count <= '0;
        end else begin
            poll_count <= poll_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            phase          <= '0;
            bit_idx        <= 3'd0;
            shift_reg      <= 8'd0;
            nes_latch      <= 1'b0;
            nes_pulse      <= 1'b0;
            buttons        <= 8'd0;
            controller_out <= 4'd0;
            frame_valid    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    phase   <= '0;
                    bit_idx <= 3'd0;
                    if (poll_tick) begin
                        state     <= S_LATCH;
                        nes_latch <= 1'b1;
                    end
                end
                S_LATCH: begin
                    if (phase == LATCH_LAST) begin
                        phase     <= '0;
                        nes_latch <= 1'b0;
                        state     <= S_GAP;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                S_GAP: begin
                    if (phase == HALF_LAST) begin
                        phase     <= '0;
                        shift_reg <= frame_bits;
                        bit_idx   <= 3'd1;
                        nes_pulse <= 1'b1;
                        state     <= S_P_HIGH;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                S_P_HIGH: begin
                    if (phase == HALF_LAST) begin
                        phase     <= '0;
                        nes_pulse <= 1'b0;
                        state     <= S_P_LOW;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                S_P_LOW: begin
                    if (phase == HALF_LAST) begin
                        phase     <= '0;
                        shift_reg <= frame_bits;
                        if (bit_idx == 3'd7) begin
                            // Publish on entry so the new values are visible during DONE.
                            buttons        <= frame_bits;
                            controller_out <= encode(frame_bits);
                            frame_valid    <= 1'b1;
                            state          <= S_DONE;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            nes_pulse <= 1'b1;
                            state     <= S_P_HIGH;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                S_DONE: begin
                    bit_idx <= 3'd0;
                    state   <= S_IDLE;
                end
                default: begin
                    state     <= S_IDLE;
                    nes_latch <= 1'b0;
                    nes_pulse <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nes_controller_reader.sv
// Bench for nes_controller_reader: behavioural pad model, directed button patterns,
// frame scoreboard and timing checks on latch/pulse/frame_valid.
module tb_nes_controller_reader;

    localparam int H = 2;
    localparam int P = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       nes_data;
    logic       nes_latch;
    logic       nes_pulse;
    logic [7:0] buttons;
    logic [3:0] controller_out;
    logic       frame_valid;
    logic [2:0] fsm_state;

    always #5 clk = ~clk;

    nes_controller_reader #(
        .HALF_BIT_CYCLES(H),
        .POLL_CYCLES    (P)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .nes_data      (nes_data),
        .nes_latch     (nes_latch),
        .nes_pulse     (nes_pulse),
        .buttons       (buttons),
        .controller_out(controller_out),
        .frame_valid   (frame_valid),
        .fsm_state     (fsm_state)
    );

    // Pad: parallel load on latch rise, shift one bit per pulse rise, active-low output.
    logic [7:0] pad_pressed = 8'd0;
    logic [7:0] pad_bits = 8'd0;
    int         pad_idx = 0;
    always @(posedge nes_latch) begin
        pad_bits = pad_pressed;
        pad_idx  = 0;
    end
    always @(posedge nes_pulse) pad_idx = pad_idx + 1;
    assign nes_data = (pad_idx < 8) ? ~pad_bits[pad_idx[2:0]] : 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [11:0] exp_q[$];
    logic overlap_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every frame_valid pops one expected {buttons, code}.
    always @(negedge clk) begin
        if (nes_latch && nes_pulse) overlap_seen = 1'b1;
        if (!reset && frame_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 32'd1, 32'd0);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                check("buttons", 32'(buttons), 32'(e[11:4]));
                check("code", 32'(controller_out), 32'(e[3:0]));
            end
        end
    end

    logic [7:0] prev_b = 8'd0;
    logic [3:0] prev_c = 4'd0;
    int  last_fv = 0;
    bit  period_ok = 1'b0;

    // Count cycles from now until nes_latch is high; -1 on timeout.
    task automatic wait_latch(output int n, output int fv_seen);
        n = -1;
        fv_seen = 0;
        for (int i = 1; i <= 4 * P; i++) begin
            @(posedge clk);
            #1;
            if (frame_valid) fv_seen++;
            if (nes_latch) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] pressed, input logic [7:0] exp_b,
                             input logic [3:0] exp_c);
        int hold_bad;
        bit found;
        hold_bad = 0;
        found = 1'b0;
        pad_pressed = pressed;
        exp_q.push_back({exp_b, exp_c});
        for (int i = 0; i < 2 * P; i++) begin
            @(posedge clk);
            #1;
            if (frame_valid) begin
                found = 1'b1;
                break;
            end
            if (buttons !== prev_b || controller_out !== prev_c) hold_bad++;
        end
        check("frame_seen", 32'(found), 32'd1);
        check("hold_between_frames", 32'(hold_bad), 32'd0);
        if (period_ok) check("frame_period", 32'(cyc - last_fv), 32'd50);
        last_fv = cyc;
        period_ok = 1'b1;
        prev_b = exp_b;
        prev_c = exp_c;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int fv_seen;
        int lat_w;
        int npulse;
        int pw;
        int pw_bad;
        int t;
        int k;
        bit got;
        logic prev_pulse;

        // Reset state, then first-frame timing with no buttons pressed.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_latch", 32'(nes_latch), 32'd0);
        check("rst_pulse", 32'(nes_pulse), 32'd0);
        check("rst_buttons", 32'(buttons), 32'd0);
        check("rst_code", 32'(controller_out), 32'd0);
        check("rst_valid", 32'(frame_valid), 32'd0);
        reset = 1'b0;
        exp_q.push_back({8'h00, 4'h0});
        wait_latch(n, fv_seen);
        check("first_latch_delay", 32'(n), 32'd50);

        lat_w = 1;
        npulse = 0;
        pw = 0;
        pw_bad = 0;
        t = 0;
        got = 1'b0;
        prev_pulse = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            t++;
            if (nes_latch) lat_w++;
            if (nes_pulse) pw++;
            else if (prev_pulse) begin
                if (pw != H) pw_bad++;
                pw = 0;
            end
            if (nes_pulse && !prev_pulse) npulse++;
            prev_pulse = nes_pulse;
            if (frame_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("latch_width", 32'(lat_w), 32'd4);
        check("pulse_count", 32'(npulse), 32'd7);
        check("pulse_width_bad", 32'(pw_bad), 32'd0);
        check("latch_to_valid", got ? 32'(t) : 32'hffff_ffff, 32'd34);
        last_fv = cyc;
        period_ok = 1'b1;

        // Directed patterns: {pressed, expected buttons, expected code}.
        run_frame(8'h40, 8'b0100_0000, 4'b0111);
        run_frame(8'h08, 8'b0000_1000, 4'b0100);
        run_frame(8'h00, 8'b0000_0000, 4'b0000);
        run_frame(8'h80, 8'b1000_0000, 4'b1000);
        run_frame(8'h06, 8'b0000_0110, 4'b0010);
        run_frame(8'h04, 8'b0000_0100, 4'b0011);
        run_frame(8'h30, 8'b0011_0000, 4'b0101);
        run_frame(8'h20, 8'b0010_0000, 4'b0110);
        run_frame(8'hC1, 8'b1100_0001, 4'b0001);

        // Reset during the high phase of the pulse that shifts bit 4.
        pad_pressed = 8'hFF;
        wait_latch(n, fv_seen);
        check("pre_reset_latch_found", 32'(n > 0), 32'd1);
        k = 0;
        prev_pulse = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (nes_pulse && !prev_pulse) k++;
            prev_pulse = nes_pulse;
            if (k == 4) break;
        end
        check("reached_bit4_pulse", 32'(k), 32'd4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_latch", 32'(nes_latch), 32'd0);
        check("midrst_pulse", 32'(nes_pulse), 32'd0);
        check("midrst_buttons", 32'(buttons), 32'd0);
        check("midrst_code", 32'(controller_out), 32'd0);
        check("midrst_valid", 32'(frame_valid), 32'd0);
        prev_b = 8'd0;
        prev_c = 4'd0;
        pad_pressed = 8'h10;
        wait_latch(n, fv_seen);
        check("latch_after_midrst", 32'(n), 32'd50);
        check("no_valid_after_midrst", 32'(fv_seen), 32'd0);
        period_ok = 1'b0;
        run_frame(8'h10, 8'b0001_0000, 4'b0101);
        run_frame(8'h02, 8'b0000_0010, 4'b0010);

        repeat (3) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("latch_pulse_overlap", 32'(overlap_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
